// File: rtl/jk_cmd_sequencer.sv
// Command sequencer driving a downstream JK flop for len+1 edges per command, with a Q reference model.
// Define JK_SEQ_CHECK_EN to build the Q-vs-model checker (err/err_cnt); otherwise they are tied to 0.
module jk_cmd_sequencer #(
  parameter int CNT_W = 8,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j_out,
  output logic             k_out,
  output logic             busy,
  output logic             done,
  output logic             exp_q,
  input  logic             q_in,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [1:0]       op, op_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic             j_n, k_n, done_n, exp_q_n;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op        <= 2'b00;
      remaining <= '0;
      j_out     <= 1'b0;
      k_out     <= 1'b0;
      done      <= 1'b0;
      exp_q     <= 1'b0;
    end else begin
      state     <= state_n;
      op        <= op_n;
      remaining <= remaining_n;
      j_out     <= j_n;
      k_out     <= k_n;
      done      <= done_n;
      exp_q     <= exp_q_n;
    end
  end

  always_comb begin
    state_n     = state;
    op_n        = op;
    remaining_n = remaining;
    j_n         = j_out;
    k_n         = k_out;
    done_n      = 1'b0;
    exp_q_n     = exp_q;
    case (state)
      IDLE: begin
        j_n = 1'b0;
        k_n = 1'b0;
        if (cmd_valid) begin
          op_n        = cmd_op;
          remaining_n = cmd_len;
          {j_n, k_n}  = cmd_op;
          state_n     = RUN;
        end
      end
      RUN: begin
        // The model advances on exactly the edges where the flop sees the latched op.
        case (op)
          2'b01:   exp_q_n = 1'b0;
          2'b10:   exp_q_n = 1'b1;
          2'b11:   exp_q_n = ~exp_q;
          default: exp_q_n = exp_q;
        endcase
        if (remaining != '0) begin
          remaining_n = remaining - CNT_W'(1);
        end else begin
          state_n = IDLE;
          j_n     = 1'b0;
          k_n     = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef JK_SEQ_CHECK_EN
  logic mismatch;
  assign mismatch = (q_in != exp_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (mismatch) begin
      err <= 1'b1;
      if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
    end
  end
`else
  logic unused_q_in;
  assign unused_q_in = q_in;
  assign err         = 1'b0;
  assign err_cnt     = '0;
`endif

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: vector table plus long-command and checker sequences.
// A behavioural JK flop closes the q_in loop; force_q inverts q_in against exp_q to provoke mismatches.
module tb_jk_cmd_sequencer;
  localparam int CNT_W = 8;
  localparam int ERR_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [CNT_W-1:0] cmd_len = '0;
  logic             j_out, k_out, busy, done, exp_q, q_in, err;
  logic [ERR_W-1:0] err_cnt;
  logic             flop_q = 1'b0;
  logic             force_q = 1'b0;

  int checks = 0;
  int fails  = 0;

  jk_cmd_sequencer #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .j_out(j_out), .k_out(k_out),
    .busy(busy), .done(done), .exp_q(exp_q), .q_in(q_in), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Downstream flop, sharing the reset net.
  always @(posedge clk) begin
    if (reset) flop_q <= 1'b0;
    else case ({j_out, k_out})
      2'b01:   flop_q <= 1'b0;
      2'b10:   flop_q <= 1'b1;
      2'b11:   flop_q <= ~flop_q;
      default: flop_q <= flop_q;
    endcase
  end

  assign q_in = force_q ? ~exp_q : flop_q;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [1:0] op;
    logic [7:0] len;
    logic       j, k, rdy, bsy, dn, eq;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t mk(input logic rst, input logic valid, input logic [1:0] op,
                              input logic [7:0] len, input logic j, input logic k,
                              input logic rdy, input logic bsy, input logic dn, input logic eq);
    vec_t v;
    v.rst = rst; v.valid = valid; v.op = op; v.len = len;
    v.j = j; v.k = k; v.rdy = rdy; v.bsy = bsy; v.dn = dn; v.eq = eq;
    return v;
  endfunction

  task automatic check_output(input string name, input int idx, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s #%0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset     = v.rst;
    cmd_valid = v.valid;
    cmd_op    = v.op;
    cmd_len   = v.len;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int busy_n, drive_n, done_n;
    logic exp_err;
    logic [ERR_W-1:0] exp_cnt1, exp_cnt_sat;

    //                rst v  op  len   j  k  rdy bsy dn eq
    vecs[0]  = mk(1, 0, 2'd0, 8'd0,  0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 0, 2'd0, 8'd0,  0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(0, 1, 2'd2, 8'd0,  1, 0, 0, 1, 0, 0);
    vecs[3]  = mk(0, 0, 2'd0, 8'd0,  0, 0, 1, 0, 1, 1);
    vecs[4]  = mk(0, 0, 2'd0, 8'd0,  0, 0, 1, 0, 0, 1);
    vecs[5]  = mk(0, 1, 2'd3, 8'd4,  1, 1, 0, 1, 0, 1);
    vecs[6]  = mk(0, 0, 2'd0, 8'd0,  1, 1, 0, 1, 0, 0);
    vecs[7]  = mk(0, 0, 2'd0, 8'd0,  1, 1, 0, 1, 0, 1);
    vecs[8]  = mk(0, 0, 2'd0, 8'd0,  1, 1, 0, 1, 0, 0);
    vecs[9]  = mk(0, 0, 2'd0, 8'd0,  1, 1, 0, 1, 0, 1);
    vecs[10] = mk(0, 0, 2'd0, 8'd0,  0, 0, 1, 0, 1, 0);
    vecs[11] = mk(0, 0, 2'd0, 8'd0,  0, 0, 1, 0, 0, 0);
    vecs[12] = mk(0, 1, 2'd2, 8'd1,  1, 0, 0, 1, 0, 0);
    vecs[13] = mk(0, 0, 2'd0, 8'd0,  1, 0, 0, 1, 0, 1);
    vecs[14] = mk(0, 0, 2'd0, 8'd0,  0, 0, 1, 0, 1, 1);
    vecs[15] = mk(0, 1, 2'd1, 8'd2,  0, 1, 0, 1, 0, 1);
    vecs[16] = mk(0, 1, 2'd3, 8'd2,  0, 1, 0, 1, 0, 0);
    vecs[17] = mk(0, 1, 2'd3, 8'd2,  0, 1, 0, 1, 0, 0);
    vecs[18] = mk(0, 1, 2'd3, 8'd0,  0, 0, 1, 0, 1, 0);
    vecs[19] = mk(0, 1, 2'd3, 8'd0,  1, 1, 0, 1, 0, 0);
    vecs[20] = mk(0, 0, 2'd0, 8'd0,  0, 0, 1, 0, 1, 1);
    vecs[21] = mk(0, 0, 2'd0, 8'd0,  0, 0, 1, 0, 0, 1);
    vecs[22] = mk(0, 1, 2'd3, 8'd10, 1, 1, 0, 1, 0, 1);
    vecs[23] = mk(0, 0, 2'd0, 8'd0,  1, 1, 0, 1, 0, 0);
    vecs[24] = mk(0, 0, 2'd0, 8'd0,  1, 1, 0, 1, 0, 1);
    vecs[25] = mk(1, 0, 2'd0, 8'd0,  0, 0, 1, 0, 0, 0);
    vecs[26] = mk(1, 0, 2'd0, 8'd0,  0, 0, 1, 0, 0, 0);
    vecs[27] = mk(0, 0, 2'd0, 8'd0,  0, 0, 1, 0, 0, 0);

    for (int i = 0; i < 28; i++) begin
      apply_stimulus(vecs[i]);
      check_output("j_out", i, j_out, vecs[i].j);
      check_output("k_out", i, k_out, vecs[i].k);
      check_output("cmd_ready", i, cmd_ready, vecs[i].rdy);
      check_output("busy", i, busy, vecs[i].bsy);
      check_output("done", i, done, vecs[i].dn);
      check_output("exp_q", i, exp_q, vecs[i].eq);
      check_output("flop_q", i, flop_q, vecs[i].eq);
      check_output("err", i, err, 1'b0);
      check_output("err_cnt", i, err_cnt, 0);
    end

    // Maximum length toggle: 256 drive edges, one done, exp_q returns to 0.
    cmd_valid = 1'b1;
    cmd_op    = 2'b11;
    cmd_len   = 8'd255;
    busy_n = 0; drive_n = 0; done_n = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) cmd_valid = 1'b0;
      if (busy) busy_n++;
      if (j_out && k_out) drive_n++;
      if (done) done_n++;
    end
    check_output("tog255_busy_cycles", 0, busy_n, 256);
    check_output("tog255_drive_edges", 0, drive_n, 256);
    check_output("tog255_done_pulses", 0, done_n, 1);
    check_output("tog255_exp_q", 0, exp_q, 1'b0);
    check_output("tog255_flop_q", 0, flop_q, 1'b0);
    check_output("tog255_ready", 0, cmd_ready, 1'b1);

`ifdef JK_SEQ_CHECK_EN
    exp_err = 1'b1; exp_cnt1 = 8'd1; exp_cnt_sat = 8'd255;
`else
    exp_err = 1'b0; exp_cnt1 = 8'd0; exp_cnt_sat = 8'd0;
`endif
    // Forced mismatch for 300 cycles.
    force_q = 1'b1;
    @(posedge clk);
    #1;
    check_output("chk_err_first", 0, err, exp_err);
    check_output("chk_cnt_first", 0, err_cnt, exp_cnt1);
    repeat (299) @(posedge clk);
    #1;
    check_output("chk_err_300", 0, err, exp_err);
    check_output("chk_cnt_sat", 0, err_cnt, exp_cnt_sat);
    force_q = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("chk_err_sticky", 0, err, exp_err);
    check_output("chk_cnt_hold", 0, err_cnt, exp_cnt_sat);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_output("post_reset_err", 0, err, 1'b0);
    check_output("post_reset_cnt", 0, err_cnt, 0);
    check_output("post_reset_ready", 0, cmd_ready, 1'b1);
    check_output("post_reset_exp_q", 0, exp_q, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
    $finish;
  end
endmodule
